// File: rtl/p4_router_pkg.sv
// Shared P4 router definitions.
// IPv4 header geometry and word access.
package p4_router_pkg;

  localparam int IPV4_HEADER_BYTES  = 20;
  localparam int IPV4_HEADER_BITS   = 160;
  localparam int IPV4_CHECKSUM_BITS = 16;
  localparam int IPV4_CHECKSUM_MSB  = 79;

  typedef logic [IPV4_HEADER_BITS-1:0] ipv4_hdr_t;

  // Word i in network order; word 5 is the checksum field.
  function automatic logic [15:0] hdr_word(
    input ipv4_hdr_t h,
    input int unsigned i
  );
    return h[159-16*i -: 16];
  endfunction

endpackage

// File: rtl/ones_comp_fold.sv
// Folds a 20-bit word sum into a 16-bit
// ones'-complement sum (two end-around steps).
module ones_comp_fold (
  input  logic [19:0] sum_i,
  output logic [15:0] fold_o
);

  logic [16:0] a;

  // Second step cannot carry: a is at most 0xFFFF+0xF.
  assign a      = {1'b0, sum_i[15:0]} + {13'd0, sum_i[19:16]};
  assign fold_o = a[15:0] + {15'd0, a[16]};

endmodule

// File: rtl/ipv4_checksum_engine.sv
// Three-stage IPv4 header checksum generate/verify
// responder with optional global-stall backpressure.
module ipv4_checksum_engine
  import p4_router_pkg::*;
#(
  parameter int USER_BITS          = 8,
  parameter int ALLOW_BACKPRESSURE = 0,
  parameter int CNT_BITS           = 32
) (
  input  logic                 clk,
  input  logic                 sreset,
  input  logic                 in_tvalid,
  output logic                 in_tready,
  input  logic [159:0]         in_tdata,
  input  logic [USER_BITS-1:0] in_tuser,
  output logic                 out_tvalid,
  input  logic                 out_tready,
  output logic [15:0]          out_checksum,
  output logic                 out_chk_ok,
  output logic [USER_BITS-1:0] out_tuser,
  output logic [CNT_BITS-1:0]  hdr_count,
  output logic [CNT_BITS-1:0]  bad_count
);

  localparam bit BP = (ALLOW_BACKPRESSURE != 0);

  logic                 adv;
  logic                 s1_vld_q;
  logic [16:0]          gen_d [5];
  logic [16:0]          ver_d [5];
  logic [16:0]          gen_q [5];
  logic [16:0]          ver_q [5];
  logic [USER_BITS-1:0] s1_user_q;
  logic                 s2_vld_q;
  logic [19:0]          s2_gen_d, s2_ver_d;
  logic [19:0]          s2_gen_q, s2_ver_q;
  logic [USER_BITS-1:0] s2_user_q;
  logic [15:0]          fold_gen, fold_ver;
  logic                 out_vld_q;
  logic [15:0]          out_cks_q;
  logic                 out_ok_q;
  logic [USER_BITS-1:0] out_user_q;
  logic [CNT_BITS-1:0]  hdr_q, hdr_d;
  logic [CNT_BITS-1:0]  bad_q, bad_d;
  logic                 done;

  assign adv       = BP ? (!out_vld_q || out_tready) : 1'b1;
  assign in_tready = BP ? (adv && !sreset) : 1'b1;

  // S1 pair sums; the gen path sees the checksum word as zero.
  always_comb begin
    for (int k = 0; k < 5; k++) begin
      gen_d[k] = {1'b0, hdr_word(in_tdata, 2*k)}
               + {1'b0, (k == 2) ? 16'h0000
                                 : hdr_word(in_tdata, 2*k+1)};
      ver_d[k] = {1'b0, hdr_word(in_tdata, 2*k)}
               + {1'b0, hdr_word(in_tdata, 2*k+1)};
    end
  end

  // S2 adder tree input: five zero-extended pair sums per path.
  always_comb begin
    s2_gen_d = 20'd0;
    s2_ver_d = 20'd0;
    for (int k = 0; k < 5; k++) begin
      s2_gen_d = s2_gen_d + {3'd0, gen_q[k]};
      s2_ver_d = s2_ver_d + {3'd0, ver_q[k]};
    end
  end

  ones_comp_fold u_fold_gen (
    .sum_i  (s2_gen_q),
    .fold_o (fold_gen)
  );

  ones_comp_fold u_fold_ver (
    .sum_i  (s2_ver_q),
    .fold_o (fold_ver)
  );

  // Pipeline registers; everything advances together on adv.
  always_ff @(posedge clk) begin
    if (sreset) begin
      s1_vld_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
      out_vld_q  <= 1'b0;
      out_cks_q  <= '0;
      out_ok_q   <= 1'b0;
      out_user_q <= '0;
    end else if (adv) begin
      s1_vld_q   <= in_tvalid && in_tready;
      gen_q      <= gen_d;
      ver_q      <= ver_d;
      s1_user_q  <= in_tuser;
      s2_vld_q   <= s1_vld_q;
      s2_gen_q   <= s2_gen_d;
      s2_ver_q   <= s2_ver_d;
      s2_user_q  <= s1_user_q;
      out_vld_q  <= s2_vld_q;
      out_cks_q  <= ~fold_gen;
      out_ok_q   <= (fold_ver == 16'hFFFF);
      out_user_q <= s2_user_q;
    end
  end

  assign done  = out_vld_q && (out_tready || !BP);
  assign hdr_d = (&hdr_q) ? hdr_q : hdr_q + 1'b1;
  assign bad_d = (&bad_q) ? bad_q : bad_q + 1'b1;

  // Saturating completion and bad-checksum counters.
  always_ff @(posedge clk) begin
    if (sreset) begin
      hdr_q <= '0;
      bad_q <= '0;
    end else if (done) begin
      hdr_q <= hdr_d;
      if (!out_ok_q) bad_q <= bad_d;
    end
  end

  assign out_tvalid   = out_vld_q;
  assign out_checksum = out_cks_q;
  assign out_chk_ok   = out_ok_q;
  assign out_tuser    = out_user_q;
  assign hdr_count    = hdr_q;
  assign bad_count    = bad_q;

endmodule
